// File: rtl/set_bit_iterator_pkg.sv
// set_bit_iterator_pkg: shared state encoding and mask helper for set_bit_iterator
package set_bit_iterator_pkg;
  localparam int MAX_W = 256;
  typedef enum logic {IDLE, ITER} state_t;
  function automatic logic [MAX_W-1:0] clr_lowest(input logic [MAX_W-1:0] mask);
    return mask & (mask - 1'b1);
  endfunction
endpackage

// File: rtl/trailing_zero_count.sv
// trailing_zero_count: number of trailing zeros of value, DATA_WIDTH when value is zero
module trailing_zero_count #(
  parameter int DATA_WIDTH = 32,
  localparam int CW = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] value,
  output logic [CW-1:0]         count
);
  always_comb begin
    count = CW'(DATA_WIDTH);
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      if (value[i]) count = CW'(i);
  end
endmodule

// File: rtl/set_bit_iterator.sv
// set_bit_iterator: emits the index of every set bit of each accepted word, lowest first
module set_bit_iterator
  import set_bit_iterator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [IDX_W-1:0]      dout_index,
  output logic [IDX_W:0]        dout_seq,
  output logic                  dout_last,
  output logic                  dout_empty,
  output logic                  dout_valid,
  input  logic                  dout_ready
);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mask, mask_clr;
  logic [IDX_W:0] seq, tz;
  logic zflag, fire, accept, last;
  trailing_zero_count #(.DATA_WIDTH(DATA_WIDTH)) u_tzc (.value(mask), .count(tz));
  assign mask_clr = DATA_WIDTH'(clr_lowest(MAX_W'(mask)));
  always_comb begin
    dout_valid = !reset && state == ITER;
    fire = dout_valid && dout_ready;
    last = dout_valid && (zflag || mask_clr == '0);
    din_ready = !reset && (state == IDLE || (fire && last));
    accept = din_valid && din_ready;
    state_n = accept ? ITER : (fire && last) ? IDLE : state;
    dout_last = last;
    dout_empty = dout_valid && zflag;
    dout_index = (dout_valid && !tz[IDX_W]) ? tz[IDX_W-1:0] : '0;
    dout_seq = dout_valid ? seq : '0;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      seq <= '0;
      zflag <= 1'b0;
    end else if (accept) begin
      mask <= din;
      seq <= '0;
      zflag <= din == '0;
    end else if (fire && !last) begin
      mask <= mask_clr;
      seq <= seq + 1'b1;
    end else if (fire) begin
      mask <= '0;
    end
  end
endmodule
